// File: rtl/nn_neuron_layer.sv
// nn_neuron_layer: N_OUT parallel float32 neurons sharing one input stream,
// with a multiply -> accumulate pipeline, bias add and per-lane activation.
module nn_neuron_layer #(
    parameter int N_IN  = 12288,
    parameter int N_OUT = 4,
    parameter int AW    = $clog2(N_IN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           act_mode,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic [31:0]          x_data,
    output logic [AW-1:0]        w_addr,
    input  logic [32*N_OUT-1:0]  w_rdata,
    input  logic [32*N_OUT-1:0]  bias,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*N_OUT-1:0]  out_data,
    output logic                 busy,
    output logic                 eoc
);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, BIAS, ACT, DONE} state_t;
    localparam logic [31:0] QNAN = 32'h7fc00000;
    state_t state;
    logic [1:0] mode;
    logic [32*N_OUT-1:0] bias_q, prod, acc;
    logic [31:0] x_reg;
    logic x_v, p_v, dcnt;
    function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
        logic s;
        logic [47:0] p;
        logic signed [9:0] e;
        logic [30:0] r;
        logic rnd;
        s = a[31] ^ b[31];
        if ((&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0])) return QNAN;
        if (&a[30:23] || &b[30:23]) return (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? QNAN : {s, 8'hff, 23'd0};
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127 + 10'(p[47]);
        if (!p[47]) p = p << 1;
        rnd = p[23] && (|p[22:0] || p[24]);
        if (e >= 10'sd255) return {s, 8'hff, 23'd0};
        if (e <= 10'sd0) return {s, 31'd0};
        r = {e[7:0], p[46:24]} + 31'(rnd);
        return {s, r};
    endfunction
    // Denormals flush to zero; rounding is to nearest even via guard/round/sticky bits.
    function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
        logic [31:0] x, y;
        logic [26:0] mx, my;
        logic [27:0] m;
        logic [7:0] d;
        logic st, rnd, sw;
        logic signed [9:0] e;
        logic [30:0] r;
        if ((&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0])) return QNAN;
        if (&a[30:23] && &b[30:23]) return a[31] == b[31] ? a : QNAN;
        if (&a[30:23]) return a;
        if (&b[30:23]) return b;
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        sw = a[30:0] < b[30:0];
        x = sw ? b : a;
        y = sw ? a : b;
        d = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'd0};
        my = {1'b1, y[22:0], 3'd0};
        if (d > 8'd26) my = 27'd1;
        else begin
            st = |(my & ((27'd1 << d) - 27'd1));
            my = (my >> d) | 27'(st);
        end
        e = 10'(x[30:23]);
        m = x[31] == y[31] ? 28'(mx) + 28'(my) : 28'(mx) - 28'(my);
        if (m == 28'd0) return 32'd0;
        if (m[27]) begin
            m = (m >> 1) | 28'(m[0]);
            e = e + 10'sd1;
        end
        for (int i = 0; i < 26; i++) if (!m[26]) begin
            m = m << 1;
            e = e - 10'sd1;
        end
        rnd = m[2] && (|m[1:0] || m[3]);
        if (e >= 10'sd255) return {x[31], 8'hff, 23'd0};
        if (e <= 10'sd0) return {x[31], 31'd0};
        r = {e[7:0], m[25:3]} + 31'(rnd);
        return {x[31], r};
    endfunction
    function automatic logic [31:0] activate(logic [31:0] v, logic [1:0] m);
        if (m == 2'b00 || !v[31]) return v;
        if (m != 2'b10) return 32'd0;
        return v[30:23] <= 8'd3 ? 32'd0 : {v[31], v[30:23] - 8'd3, v[22:0]};
    endfunction
    assign x_ready = state == RUN;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mode <= 2'b00;
            bias_q <= '0;
            prod <= '0;
            acc <= '0;
            x_reg <= '0;
            x_v <= 1'b0;
            p_v <= 1'b0;
            dcnt <= 1'b0;
            w_addr <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            eoc <= 1'b0;
        end else begin
            eoc <= 1'b0;
            x_v <= x_valid && x_ready;
            if (x_valid && x_ready) x_reg <= x_data;
            p_v <= x_v;
            for (int j = 0; j < N_OUT; j++) begin
                if (x_v) prod[32*j +: 32] <= fmul(x_reg, w_rdata[32*j +: 32]);
                if (p_v) acc[32*j +: 32] <= fadd(acc[32*j +: 32], prod[32*j +: 32]);
            end
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    w_addr <= '0;
                    acc <= '0;
                    prod <= '0;
                    x_v <= 1'b0;
                    p_v <= 1'b0;
                    mode <= act_mode;
                    bias_q <= bias;
                end
                RUN: if (x_valid) begin
                    if (w_addr == AW'(N_IN - 1)) begin
                        state <= DRAIN;
                        dcnt <= 1'b0;
                    end else w_addr <= w_addr + 1'b1;
                end
                // Two drain cycles let the last product reach the accumulator.
                DRAIN: begin
                    dcnt <= 1'b1;
                    if (dcnt) state <= BIAS;
                end
                BIAS: begin
                    for (int j = 0; j < N_OUT; j++) acc[32*j +: 32] <= fadd(acc[32*j +: 32], bias_q[32*j +: 32]);
                    state <= ACT;
                end
                ACT: begin
                    for (int j = 0; j < N_OUT; j++) out_data[32*j +: 32] <= activate(acc[32*j +: 32], mode);
                    out_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    eoc <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_neuron_layer.sv
// tb_nn_neuron_layer: scoreboard bench for a 4-input, 2-lane neuron layer.
module tb_nn_neuron_layer;
    localparam int N_IN = 4;
    localparam int N_OUT = 2;
    localparam int AW = 2;
    localparam logic [63:0] RELU_RES = {32'h00000000, 32'h41280000};
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, x_valid = 1'b0, out_ready = 1'b1;
    logic [1:0] act_mode = 2'b00;
    logic [31:0] x_data = 32'd0;
    logic [63:0] w_rdata, bias, out_data;
    logic [AW-1:0] w_addr;
    logic x_ready, out_valid, busy, eoc;
    logic [31:0] xs[N_IN], w0[N_IN], w1[N_IN];
    logic [63:0] exp_q[$];
    logic [63:0] hold;
    int n_vec = 0, n_err = 0;
    nn_neuron_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .act_mode(act_mode),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .w_addr(w_addr), .w_rdata(w_rdata), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .eoc(eoc)
    );
    always #5 clk = ~clk;
    always @(posedge clk) w_rdata <= {w1[w_addr], w0[w_addr]};
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) check("q_empty", 64'(exp_q.size()), 64'd1);
        else check("out_data", out_data, exp_q.pop_front());
    end
    task automatic run(input logic [1:0] mode, input int gap, input logic [63:0] exp);
        int cnt;
        logic [63:0] b;
        b = bias;
        exp_q.push_back(exp);
        act_mode = mode;
        start = 1'b1;
        step;
        start = 1'b0;
        act_mode = ~mode;
        bias = ~bias;
        check("busy_run", busy, 1);
        for (int i = 0; i < N_IN; i++) begin
            check("w_addr", w_addr, i);
            check("x_ready", x_ready, 1);
            x_valid = 1'b1;
            x_data = xs[i];
            step;
            x_valid = 1'b0;
            x_data = 32'hdeadbeef;
            if (i < N_IN - 1) repeat (gap) begin
                check("x_ready_gap", x_ready, 1);
                step;
            end
        end
        check("w_addr_hold", w_addr, N_IN - 1);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            step;
            cnt++;
        end
        check("latency", cnt, 4);
        act_mode = 2'b00;
        bias = b;
    endtask
    task automatic finish_out(input logic st);
        start = st;
        step;
        start = 1'b0;
        check("eoc_hi", eoc, 1);
        check("busy_idle", busy, 0);
        step;
        check("eoc_lo", eoc, 0);
        check("busy_stay_idle", busy, 0);
    endtask
    task automatic check_reset_outs;
        check("rst_x_ready", x_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_eoc", eoc, 0);
        check("rst_busy", busy, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_out_data", out_data, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        xs = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        for (int i = 0; i < N_IN; i++) begin
            w0[i] = 32'h3F800000;
            w1[i] = 32'hBF800000;
        end
        bias = {32'h3F000000, 32'h3F000000};
        step;
        step;
        check_reset_outs;
        rst_n = 1'b1;
        step;
        run(2'b01, 0, RELU_RES);
        finish_out(1'b0);
        run(2'b00, 0, {32'hC1180000, 32'h41280000});
        finish_out(1'b0);
        run(2'b10, 0, {32'hBF980000, 32'h41280000});
        finish_out(1'b0);
        run(2'b11, 0, RELU_RES);
        finish_out(1'b0);
        run(2'b01, 2, RELU_RES);
        finish_out(1'b0);
        out_ready = 1'b0;
        run(2'b01, 0, RELU_RES);
        hold = out_data;
        for (int i = 0; i < 10; i++) begin
            start = i == 3;
            check("bp_data", out_data, hold);
            check("bp_valid", out_valid, 1);
            check("bp_busy", busy, 1);
            check("bp_eoc", eoc, 0);
            step;
            start = 1'b0;
        end
        out_ready = 1'b1;
        finish_out(1'b1);
        act_mode = 2'b01;
        start = 1'b1;
        step;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            x_valid = 1'b1;
            x_data = xs[i];
            step;
        end
        x_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outs;
        step;
        check_reset_outs;
        rst_n = 1'b1;
        step;
        run(2'b01, 0, RELU_RES);
        finish_out(1'b0);
        for (int i = 0; i < N_IN; i++) xs[i] = 32'h0;
        bias = {32'hC1280000, 32'h3F000000};
        run(2'b10, 0, {32'hBFA80000, 32'h3F000000});
        finish_out(1'b0);
        check("q_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nn_neuron_layer.md
NN_NEURON_LAYER -- requirements
Module: nn_neuron_layer

Interface
REQ-001 Parameter N_IN, default 12288: number of inputs accumulated per result.
REQ-002 Parameter N_OUT, default 4: number of neurons computed in parallel, sharing one input stream.
REQ-003 Parameter AW, default $clog2(N_IN): weight address width.
REQ-004 clk  in  1: single clock, all state updates on the rising edge.
REQ-005 rst_n  in  1: asynchronous, active-low reset.
REQ-006 start  in  1: begin a new computation; accepted only in IDLE.
REQ-007 act_mode  in  2: activation select. 00 = none, 01 = ReLU, 10 = leaky ReLU (slope 1/8), 11 = ReLU.
REQ-008 x_valid / x_ready  in / out  1 / 1: input handshake for x_data.
REQ-009 x_data  in  32: IEEE-754 single-precision input value.
REQ-010 w_addr  out  AW: weight index, equal to the current input count.
REQ-011 w_rdata  in  32*N_OUT: weights for all neurons at w_addr, from a synchronous RAM with 1-cycle read latency; neuron j uses bits [32j+31:32j].
REQ-012 bias  in  32*N_OUT: per-neuron biases, sampled on start acceptance.
REQ-013 out_valid / out_ready  out / in  1 / 1: result handshake.
REQ-014 out_data  out  32*N_OUT: activated results.
REQ-015 busy  out  1: high in every state except IDLE.
REQ-016 eoc  out  1: end-of-computation pulse.

Function
REQ-017 FSM states are IDLE, RUN, DRAIN, BIAS, ACT and DONE, with these transitions:
- IDLE to RUN when start is high.
- RUN to DRAIN on the N_IN-th x handshake.
- DRAIN to BIAS after 2 cycles.
- BIAS to ACT after 1 cycle.
- ACT to DONE after 1 cycle.
- DONE to IDLE on the out handshake.
REQ-018 On start acceptance: input count, accumulators and product registers clear to 0; act_mode and bias are captured.
REQ-019 x_ready is high only in RUN; an x handshake is x_valid && x_ready; x_valid outside RUN is ignored.
REQ-020 w_addr equals the count of x handshakes completed so far in this run, over the range 0..N_IN-1; it holds at N_IN-1 after the last handshake and does not wrap.
REQ-021 Each handshake registers x_data; on the next edge, prod[j] <= FloatMul(x_reg, w_rdata[j]) for every j.
REQ-022 One edge after that, acc[j] <= AdditionSubtraction(acc[j], prod[j], add). Products enter the accumulator strictly in input order, with no reassociation.
REQ-023 Gaps in x_valid insert bubbles: a product register without a new product contributes nothing to the accumulator.
REQ-024 In BIAS, acc[j] <= acc[j] + bias[j].
REQ-025 In ACT, activation is applied per lane and registered into out_data:
- none: value passes unchanged.
- ReLU: sign bit 1 gives +0 (0x00000000), including -0 and negative NaN; otherwise the value passes.
- leaky: a negative value has its exponent reduced by 3; if the exponent field is <= 3 the result is +0; a non-negative value passes.
REQ-026 Latency: out_valid rises exactly 4 clock edges after the edge accepting the last x.
REQ-027 In DONE, out_valid stays high and out_data stays stable until out_ready is high.
REQ-028 On the out handshake, eoc pulses high for exactly 1 cycle and the FSM returns to IDLE.
REQ-029 start while busy is ignored, including start during DONE under backpressure.
REQ-030 A start arriving in the same cycle as the out handshake is ignored; start must be reasserted in IDLE.
REQ-031 Changes to act_mode or bias after start acceptance do not affect the current run.
REQ-032 NaN, infinity and denormal handling follows FloatMul and AdditionSubtraction unchanged.

Reset
REQ-033 rst_n low, asynchronously at any time including mid-run, forces the following:
- FSM to IDLE.
- x_ready = 0, out_valid = 0, eoc = 0, busy = 0.
- w_addr = 0 and out_data = 0.
- All accumulators and product registers cleared to 0.
REQ-034 After rst_n deasserts, the first start is accepted normally and no state from the interrupted run survives.

Verification (N_IN = 4, N_OUT = 2, bias = 0x3F000000 for both lanes, x = 0x3F800000, 0x40000000, 0x40400000, 0x40800000, lane 0 weights all 1.0, lane 1 weights all -1.0)
REQ-035 ReLU, x_valid held high -> out_data = {0x00000000, 0x41280000}, w_addr steps 0,1,2,3, and out_valid rises 4 edges after the last x.
REQ-036 Mode none -> lane 1 = 0xC1180000; leaky -> lane 1 = 0xBF980000; in both modes lane 0 = 0x41280000.
REQ-037 x_valid with 2-cycle gaps between items -> same results as REQ-035; x_ready stays high throughout RUN.
REQ-038 out_ready low for 10 cycles with start pulsed during them -> out_data is stable, busy = 1, the start is ignored, and eoc pulses once when out_ready rises.
REQ-039 rst_n low after the 2nd x, then a full rerun -> all outputs read 0 during reset, and the rerun result equals REQ-035.
REQ-040 Lane 1 bias = 0xC1280000 (-10.5) with all-zero inputs under leaky mode -> lane 1 result = 0xBFA80000.
